l1_dm_arb: RTL and testbench
============================

# l1_dm_arb

Two-requester arbiter and sequencer for the L1 data-cache data SRAM (single-port, byte-enable, one-cycle read latency). It shares the one SRAM port between the core load/store path and the refill/evict path from L2. Each cycle it picks at most one requester and drives the SRAM enable, address, write and byte-enable. It returns read data to the owner one cycle later. Fill has priority, and a bounded-starvation counter guarantees core progress.

## Interface
- WIDTH, 32, data word width in bits; a multiple of 8.
- DEPTH, 1024, SRAM words; address width AW = $clog2(DEPTH).
- STARVE_MAX, 4, number of consecutive lost conflicts after which the core wins the next conflict; range 1..15.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- core_req_val  in  1  core request valid.
- core_req_ack  out  1  core request accepted this cycle.
- core_addr  in  AW  core word address.
- core_we  in  1  1 = write, 0 = read.
- core_wbe  in  WIDTH/8  core byte enables; used on writes only.
- core_wdata  in  WIDTH  core write data.
- core_rdata_val  out  1  core read data valid.
- core_rdata  out  WIDTH  core read data.
- fill_req_val  in  1  refill/evict request valid.
- fill_req_ack  out  1  fill request accepted this cycle.
- fill_addr  in  AW  fill word address.
- fill_we  in  1  1 = refill write (full word), 0 = evict read.
- fill_wdata  in  WIDTH  refill write data.
- fill_rdata_val  out  1  evict read data valid.
- fill_rdata  out  WIDTH  evict read data.
- mem_en  out  1  SRAM enable.
- mem_addr  out  AW  SRAM address.
- mem_we  out  1  SRAM write.
- mem_wbe  out  WIDTH/8  SRAM byte enables.
- mem_wdata  out  WIDTH  SRAM write data.
- mem_rdata  in  WIDTH  SRAM read data; valid the cycle after an enabled read.

## Operation
**Grant rule** (combinational, same cycle):
- While RST = 1: no grant.
- Only one requester valid: that requester is granted.
- Both valid: fill is granted unless starve_cnt == STARVE_MAX, in which case core is granted.

**Acknowledge:**
- core_req_ack = core granted.
- fill_req_ack = fill granted.
- A request transfers when val & ack are both 1. A requester that is not acked holds its request stable.

**SRAM drive:**
- mem_en = 1 exactly when a grant is issued.
- mem_addr, mem_we and mem_wdata come from the granted requester.
- mem_wbe: core_wbe for a core grant; all ones for a fill grant.
- With no grant, mem_en = 0 and mem_we = 0.
- mem_wbe = 0 whenever mem_we = 0.

**starve_cnt** (width $clog2(STARVE_MAX+1)):
- Increments when both requesters are valid and fill is granted.
- Clears when core is granted.
- Holds otherwise; never exceeds STARVE_MAX.

**Response tracking:**
- rsp_core and rsp_fill are registers.
- Each is set for one cycle after a granted read (we = 0) by its owner.
- Writes produce no response.

**Read data:**
- core_rdata_val = rsp_core; fill_rdata_val = rsp_fill; at most one is 1 per cycle.
- core_rdata and fill_rdata both pass mem_rdata straight through and are meaningful only while the matching valid is 1.

**Reset:** on the RST clock edge:
- starve_cnt = 0, rsp_core = 0, rsp_fill = 0.
- All outputs are 0 while RST = 1: acks, mem_en, mem_we, mem_wbe, both rdata_val.
- A read granted in the cycle before RST asserts has its response dropped: the valid stays 0.

## Timing
- Request-to-ack latency is 0 cycles when uncontended.
- Read latency: data valid exactly 1 cycle after the acked cycle.
- Throughput: one access per cycle; back-to-back reads give a valid on every following cycle.
- Under continuous contention the core is served at least once every STARVE_MAX+1 cycles.
- A write followed by a read of the same address on the next cycle returns the new data, because the SRAM is write-before-read across cycles.
- There are no combinational paths from mem_rdata to any ack.

## Test plan
- **Reset:** hold RST for 3 cycles with both requests valid → all acks, mem_en and rdata_val are 0. After release, fill is acked first and starve_cnt starts at 0.
- **Core write then read:** core writes addr 0x10, wbe 4'b0101, data 0xAABBCCDD over an initial 0x11223344. The next-cycle read returns core_rdata_val = 1 with 0x11BB33DD.
- **Starvation:** core and fill request continuously with STARVE_MAX = 4 → grant pattern F,F,F,F,C repeating. The core gets 1 ack per 5 cycles.
- **Evict read routing:** fill read of addr 0x3FF → fill_rdata_val = 1 one cycle later with the stored word. core_rdata_val stays 0.
- **Refill write:** fill writes 0xDEADBEEF to addr 5 → mem_wbe = 4'b1111. A core read of addr 5 on the next cycle returns 0xDEADBEEF.
- **Reset mid-read:** core read acked at cycle N, RST high at cycle N+1 → core_rdata_val = 0 at cycle N+1, and no spurious valid follows.

Source files
------------

// File: rtl/l1_dm_arb.sv
// l1_dm_arb: shares the single-port L1 data SRAM between the core
// load/store path and the L2 refill/evict path. Fill wins conflicts
// except when the core has lost STARVE_MAX conflicts in a row.
module l1_dm_arb #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1024,
  parameter int STARVE_MAX = 4,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 core_req_val,
  output logic                 core_req_ack,
  input  logic [AW-1:0]        core_addr,
  input  logic                 core_we,
  input  logic [WIDTH/8-1:0]   core_wbe,
  input  logic [WIDTH-1:0]     core_wdata,
  output logic                 core_rdata_val,
  output logic [WIDTH-1:0]     core_rdata,
  input  logic                 fill_req_val,
  output logic                 fill_req_ack,
  input  logic [AW-1:0]        fill_addr,
  input  logic                 fill_we,
  input  logic [WIDTH-1:0]     fill_wdata,
  output logic                 fill_rdata_val,
  output logic [WIDTH-1:0]     fill_rdata,
  output logic                 mem_en,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_we,
  output logic [WIDTH/8-1:0]   mem_wbe,
  output logic [WIDTH-1:0]     mem_wdata,
  input  logic [WIDTH-1:0]     mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CORE,
    GNT_FILL
  } gnt_e;

  gnt_e          gnt;
  logic [SW-1:0] starve_cnt;
  logic          rsp_core;
  logic          rsp_fill;

  // Grant selection: fill has priority unless the core has starved.
  always_comb begin
    gnt = GNT_NONE;
    if (!RST) begin
      if (core_req_val && fill_req_val)
        gnt = (starve_cnt == STARVE_LIM) ? GNT_CORE : GNT_FILL;
      else if (core_req_val)
        gnt = GNT_CORE;
      else if (fill_req_val)
        gnt = GNT_FILL;
    end
  end

  // SRAM port drive from the granted requester; idle port is all zeros.
  always_comb begin
    core_req_ack = 1'b0;
    fill_req_ack = 1'b0;
    mem_en       = 1'b0;
    mem_addr     = '0;
    mem_we       = 1'b0;
    mem_wbe      = '0;
    mem_wdata    = '0;
    case (gnt)
      GNT_CORE: begin
        core_req_ack = 1'b1;
        mem_en       = 1'b1;
        mem_addr     = core_addr;
        mem_we       = core_we;
        mem_wbe      = core_we ? core_wbe : '0;
        mem_wdata    = core_wdata;
      end
      GNT_FILL: begin
        fill_req_ack = 1'b1;
        mem_en       = 1'b1;
        mem_addr     = fill_addr;
        mem_we       = fill_we;
        mem_wbe      = fill_we ? '1 : '0;
        mem_wdata    = fill_wdata;
      end
      default: ;
    endcase
  end

  // Count consecutive conflicts lost by the core; a core grant clears it.
  always_ff @(posedge CLK) begin
    if (RST)
      starve_cnt <= '0;
    else if (gnt == GNT_CORE)
      starve_cnt <= '0;
    else if (gnt == GNT_FILL && core_req_val)
      starve_cnt <= starve_cnt + SW'(1);
  end

  // Remember which requester owns the read data returning next cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_core <= 1'b0;
      rsp_fill <= 1'b0;
    end else begin
      rsp_core <= (gnt == GNT_CORE) && !core_we;
      rsp_fill <= (gnt == GNT_FILL) && !fill_we;
    end
  end

  // Valids are masked by RST so a response in flight at reset is dropped.
  assign core_rdata_val = rsp_core & ~RST;
  assign fill_rdata_val = rsp_fill & ~RST;
  assign core_rdata     = mem_rdata;
  assign fill_rdata     = mem_rdata;

endmodule

// File: tb/tb_l1_dm_arb.sv
// Directed bench for l1_dm_arb with a behavioural byte-enable SRAM.
module tb_l1_dm_arb;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic             CLK = 1'b0;
  logic             RST;
  logic             core_req_val, core_req_ack, core_we;
  logic [AW-1:0]    core_addr;
  logic [3:0]       core_wbe;
  logic [WIDTH-1:0] core_wdata, core_rdata;
  logic             core_rdata_val;
  logic             fill_req_val, fill_req_ack, fill_we;
  logic [AW-1:0]    fill_addr;
  logic [WIDTH-1:0] fill_wdata, fill_rdata;
  logic             fill_rdata_val;
  logic             mem_en, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [3:0]       mem_wbe;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  logic [WIDTH-1:0] sram [DEPTH];

  int tests = 0;
  int fails = 0;

  l1_dm_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .core_req_val(core_req_val), .core_req_ack(core_req_ack),
    .core_addr(core_addr), .core_we(core_we), .core_wbe(core_wbe),
    .core_wdata(core_wdata), .core_rdata_val(core_rdata_val),
    .core_rdata(core_rdata),
    .fill_req_val(fill_req_val), .fill_req_ack(fill_req_ack),
    .fill_addr(fill_addr), .fill_we(fill_we), .fill_wdata(fill_wdata),
    .fill_rdata_val(fill_rdata_val), .fill_rdata(fill_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wbe(mem_wbe), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  // SRAM: byte-enable write, one-cycle registered read.
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wbe[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge to change inputs.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    core_req_val = 1'b0; fill_req_val = 1'b0;
    core_we = 1'b0; fill_we = 1'b0;
  endtask

  int  core_acks;
  logic prev_fill, prev_core;

  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] = '0;
    mem_rdata = '0;
    RST = 1'b1;
    core_addr = 10'h010; core_we = 1'b0; core_wbe = 4'hF; core_wdata = '0;
    fill_addr = 10'h3FF; fill_we = 1'b0; fill_wdata = '0;
    core_req_val = 1'b1; fill_req_val = 1'b1;

    // Reset held three cycles with both requests valid.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rst_core_ack", {31'b0, core_req_ack}, 32'd0);
      check("rst_fill_ack", {31'b0, fill_req_ack}, 32'd0);
      check("rst_mem_en", {31'b0, mem_en}, 32'd0);
      check("rst_mem_we_wbe", {27'b0, mem_we, mem_wbe}, 32'd0);
      check("rst_rvals", {30'b0, core_rdata_val, fill_rdata_val}, 32'd0);
      if (i < 2) step();
    end

    // Continuous contention: F,F,F,F,C repeating from a cleared counter.
    step(); RST = 1'b0;
    core_acks = 0; prev_fill = 1'b0; prev_core = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("starve_fill_ack", {31'b0, fill_req_ack}, (i % 5 != 4) ? 32'd1 : 32'd0);
      check("starve_core_ack", {31'b0, core_req_ack}, (i % 5 == 4) ? 32'd1 : 32'd0);
      check("starve_rvals", {30'b0, core_rdata_val, fill_rdata_val},
            {30'b0, prev_core, prev_fill});
      prev_fill = (i % 5 != 4);
      prev_core = (i % 5 == 4);
      if (core_req_ack) core_acks++;
      step();
    end
    check("starve_core_count", core_acks, 32'd2);

    // Fill write of initial word at 0x10.
    idle();
    fill_req_val = 1'b1; fill_we = 1'b1; fill_addr = 10'h010; fill_wdata = 32'h11223344;
    @(negedge CLK);
    check("fill_wr_ack", {31'b0, fill_req_ack}, 32'd1);
    check("fill_wr_wbe", {27'b0, mem_we, mem_wbe}, 32'h1F);

    // Core partial write.
    step(); idle();
    core_req_val = 1'b1; core_we = 1'b1; core_addr = 10'h010;
    core_wbe = 4'b0101; core_wdata = 32'hAABBCCDD;
    @(negedge CLK);
    check("core_wr_ack", {31'b0, core_req_ack}, 32'd1);
    check("core_wr_wbe", {27'b0, mem_we, mem_wbe}, 32'h15);
    check("core_wr_addr", {22'b0, mem_addr}, 32'h010);
    check("core_wr_data", mem_wdata, 32'hAABBCCDD);

    // Core read of the same address next cycle.
    step(); core_we = 1'b0;
    @(negedge CLK);
    check("core_rd_ack", {31'b0, core_req_ack}, 32'd1);
    check("core_rd_we_wbe", {27'b0, mem_we, mem_wbe}, 32'd0);
    step(); idle();
    @(negedge CLK);
    check("core_rd_val", {30'b0, core_rdata_val, fill_rdata_val}, 32'd2);
    check("core_rd_data", core_rdata, 32'h11BB33DD);
    check("idle_mem_en", {31'b0, mem_en}, 32'd0);

    // Evict read of 0x3FF after seeding it.
    step();
    fill_req_val = 1'b1; fill_we = 1'b1; fill_addr = 10'h3FF; fill_wdata = 32'h12345678;
    step(); fill_we = 1'b0;
    @(negedge CLK);
    check("evict_ack", {31'b0, fill_req_ack}, 32'd1);
    step(); idle();
    @(negedge CLK);
    check("evict_val", {30'b0, core_rdata_val, fill_rdata_val}, 32'd1);
    check("evict_data", fill_rdata, 32'h12345678);

    // Refill write then back-to-back core reads of 5 and 0x10.
    step();
    fill_req_val = 1'b1; fill_we = 1'b1; fill_addr = 10'd5; fill_wdata = 32'hDEADBEEF;
    @(negedge CLK);
    check("refill_wbe", {27'b0, mem_we, mem_wbe}, 32'h1F);
    step(); idle();
    core_req_val = 1'b1; core_addr = 10'd5;
    @(negedge CLK);
    check("rd5_ack", {31'b0, core_req_ack}, 32'd1);
    step(); core_addr = 10'h010;
    @(negedge CLK);
    check("b2b_val1", {30'b0, core_rdata_val, fill_rdata_val}, 32'd2);
    check("b2b_data1", core_rdata, 32'hDEADBEEF);
    step(); idle();
    @(negedge CLK);
    check("b2b_val2", {30'b0, core_rdata_val, fill_rdata_val}, 32'd2);
    check("b2b_data2", core_rdata, 32'h11BB33DD);

    // Reset arriving the cycle after a granted read drops the response.
    step();
    core_req_val = 1'b1; core_addr = 10'd5;
    @(negedge CLK);
    check("midrst_ack", {31'b0, core_req_ack}, 32'd1);
    step(); idle(); RST = 1'b1;
    @(negedge CLK);
    check("midrst_val_n1", {30'b0, core_rdata_val, fill_rdata_val}, 32'd0);
    step(); RST = 1'b0;
    @(negedge CLK);
    check("midrst_val_n2", {30'b0, core_rdata_val, fill_rdata_val}, 32'd0);
    check("midrst_mem_en", {31'b0, mem_en}, 32'd0);

    // Counter cleared by reset: fill wins the first conflict.
    step();
    core_req_val = 1'b1; fill_req_val = 1'b1;
    @(negedge CLK);
    check("post_rst_fill_first", {30'b0, core_req_ack, fill_req_ack}, 32'd1);
    step(); idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
